// File: rtl/pll_led_sequencer.sv
// Lock-filtered LED sequencer for the CC_PLL CLK0 domain: per-channel off/on/blink/breathe.
// Optional lock-drop statistics are built when PLL_LED_LOCK_STATS_EN is defined.

module pll_led_lane #(
  parameter int PWM_W = 8
) (
  input  logic [PWM_W:0]   tap_win,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic [1:0]       mode,
  output logic             led
);
  logic [PWM_W-1:0] duty;

  always_comb begin
    // Top tap bit selects ramp direction, giving a triangle-wave duty.
    duty = tap_win[PWM_W] ? ~tap_win[PWM_W-1:0] : tap_win[PWM_W-1:0];
    case (mode)
      2'b00:   led = 1'b0;
      2'b01:   led = 1'b1;
      2'b10:   led = tap_win[PWM_W];
      default: led = (pwm_cnt < duty);
    endcase
  end
endmodule

module pll_led_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 29,
  parameter int TAP_BASE    = 23,
  parameter int LOCK_FILT_W = 8,
  parameter int PWM_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic [2*CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0]   led,
  output logic                  running,
  output logic [7:0]            lock_lost
);
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LOCK_FILT_W-1:0] filt_q, filt_d;
  logic [CHANNELS-1:0]    led_q, led_d, lane_led;
  logic                   running_q, running_d;
  logic                   lost_inc;
  logic                   lock_s;

  assign lock_s = sync_q[1];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    pll_led_lane #(.PWM_W(PWM_W)) u_lane (
      .tap_win (cnt_q[TAP_BASE+gi -: PWM_W+1]),
      .pwm_cnt (cnt_q[PWM_W-1:0]),
      .mode    (mode[2*gi +: 2]),
      .led     (lane_led[gi])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    filt_d   = filt_q;
    lost_inc = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d  = '0;
        filt_d = '0;
        if (lock_s) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          filt_d   = '0;
          lost_inc = 1'b1;
        end else if (&filt_q) begin
          state_d = RUN;
        end else begin
          filt_d = filt_q + LOCK_FILT_W'(1);
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          lost_inc = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    // Outputs follow the next state so led and running change on the same edge.
    running_d = (state_d == RUN);
    led_d     = running_d ? lane_led : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      filt_q    <= '0;
      led_q     <= '0;
      running_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], pll_locked};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      filt_q    <= filt_d;
      led_q     <= led_d;
      running_q <= running_d;
    end
  end

  assign led     = led_q;
  assign running = running_q;

`ifdef PLL_LED_LOCK_STATS_EN
  logic [7:0] lock_lost_q, lock_lost_d;

  always_comb begin
    lock_lost_d = lock_lost_q;
    if (lost_inc && lock_lost_q != 8'hFF) lock_lost_d = lock_lost_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_lost_q <= '0;
    else     lock_lost_q <= lock_lost_d;
  end

  assign lock_lost = lock_lost_q;
`else
  logic unused_lost_inc;
  assign unused_lost_inc = lost_inc;
  assign lock_lost       = 8'd0;
`endif
endmodule
